// File: rtl/multi_ballot_controller.sv
// Ballot controller: voter authentication against a voted-flag registry, one vote per ID,
// saturating per-candidate tallies and a one-candidate-per-cycle winner scan.
module multi_ballot_controller #(
    parameter int unsigned ID_W     = 8,
    parameter int unsigned NUM_CAND = 8,
    parameter int unsigned CAND_W   = 4,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned ID_MIN   = 1,
    parameter int unsigned ID_MAX   = 200,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              poll_close,
    input  logic              auth_req,
    input  logic [ID_W-1:0]   voter_id,
    input  logic              submit,
    input  logic              cancel,
    input  logic [CAND_W-1:0] cand_sel,
    input  logic              result_req,
    output logic              ready,
    output logic [1:0]        state,
    output logic              vote_accepted,
    output logic              vote_rejected,
    output logic [2:0]        err_code,
    output logic [CNT_W-1:0]  total_votes,
    output logic [CAND_W-1:0] winner_id,
    output logic [CNT_W-1:0]  winner_votes,
    output logic              tie,
    output logic              results_valid
);
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSession = 2'd1,
        StScan    = 2'd2,
        StClosed  = 2'd3
    } state_t;

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned SW = CAND_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             cur;
    logic [2**ID_W-1:0] voted;
    logic [CNT_W-1:0]   counts [NUM_CAND];
    logic [ID_W-1:0]    voter;
    logic [TW-1:0]      idle_cnt;
    logic [SW-1:0]      scan_idx;
    logic               scan_from_closed;
    logic               close_pending;
    logic [CAND_W-1:0]  best_id;
    logic [CNT_W-1:0]   best_votes;
    logic               tie_acc;
    logic [CNT_W-1:0]   scan_cnt;
    logic               id_in_range;
    logic               cand_valid;

    assign state       = cur;
    assign id_in_range = (32'(voter_id) >= ID_MIN) && (32'(voter_id) <= ID_MAX);
    assign cand_valid  = 32'(cand_sel) < NUM_CAND;

    always_comb begin
        scan_cnt = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (scan_idx == SW'(i)) scan_cnt = counts[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur              <= StIdle;
            voted            <= '0;
            for (int i = 0; i < NUM_CAND; i++) counts[i] <= '0;
            voter            <= '0;
            idle_cnt         <= '0;
            scan_idx         <= '0;
            scan_from_closed <= 1'b0;
            close_pending    <= 1'b0;
            best_id          <= '0;
            best_votes       <= '0;
            tie_acc          <= 1'b0;
            ready            <= 1'b0;
            vote_accepted    <= 1'b0;
            vote_rejected    <= 1'b0;
            err_code         <= 3'd0;
            total_votes      <= '0;
            winner_id        <= '0;
            winner_votes     <= '0;
            tie              <= 1'b0;
            results_valid    <= 1'b0;
        end else begin
            ready         <= enable;
            vote_accepted <= 1'b0;
            vote_rejected <= 1'b0;
            if (!enable) begin
                // An aborted scan started from CLOSED falls back to CLOSED, which never reopens.
                if (cur == StSession) begin
                    cur <= StIdle;
                end else if (cur == StScan) begin
                    cur           <= scan_from_closed ? StClosed : StIdle;
                    results_valid <= 1'b0;
                end
            end else begin
                case (cur)
                    StIdle: begin
                        if (poll_close) begin
                            cur <= StClosed;
                        end else if (auth_req) begin
                            if (!id_in_range) begin
                                vote_rejected <= 1'b1;
                                err_code      <= 3'd1;
                            end else if (voted[voter_id]) begin
                                vote_rejected <= 1'b1;
                                err_code      <= 3'd2;
                            end else begin
                                voter    <= voter_id;
                                err_code <= 3'd0;
                                idle_cnt <= '0;
                                cur      <= StSession;
                            end
                        end else if (result_req) begin
                            cur              <= StScan;
                            scan_idx         <= '0;
                            results_valid    <= 1'b0;
                            scan_from_closed <= 1'b0;
                            close_pending    <= 1'b0;
                        end
                    end
                    StSession: begin
                        if (poll_close) begin
                            cur <= StClosed;
                        end else if (cancel) begin
                            cur <= StIdle;
                        end else if (submit) begin
                            if (cand_valid) begin
                                for (int i = 0; i < NUM_CAND; i++) begin
                                    if (cand_sel == CAND_W'(i) && counts[i] != CNT_MAX)
                                        counts[i] <= counts[i] + CNT_W'(1);
                                end
                                if (total_votes != CNT_MAX) total_votes <= total_votes + CNT_W'(1);
                                voted[voter]  <= 1'b1;
                                vote_accepted <= 1'b1;
                                err_code      <= 3'd0;
                                results_valid <= 1'b0;
                                cur           <= StIdle;
                            end else begin
                                vote_rejected <= 1'b1;
                                err_code      <= 3'd3;
                                idle_cnt      <= '0;
                            end
                        end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
                            vote_rejected <= 1'b1;
                            err_code      <= 3'd4;
                            cur           <= StIdle;
                        end else begin
                            idle_cnt <= idle_cnt + TW'(1);
                        end
                    end
                    StScan: begin
                        if (poll_close) close_pending <= 1'b1;
                        if (32'(scan_idx) < NUM_CAND) begin
                            // Strictly-greater keeps the lower index on equal counts.
                            if (scan_idx == '0 || scan_cnt > best_votes) begin
                                best_id    <= scan_idx[CAND_W-1:0];
                                best_votes <= scan_cnt;
                                tie_acc    <= 1'b0;
                            end else if (scan_cnt == best_votes) begin
                                tie_acc <= 1'b1;
                            end
                            scan_idx <= scan_idx + SW'(1);
                        end else begin
                            winner_id     <= best_id;
                            winner_votes  <= best_votes;
                            tie           <= tie_acc;
                            results_valid <= 1'b1;
                            cur <= (scan_from_closed || close_pending || poll_close) ? StClosed
                                                                                     : StIdle;
                        end
                    end
                    StClosed: begin
                        if (auth_req) begin
                            vote_rejected <= 1'b1;
                            err_code      <= 3'd5;
                        end else if (result_req) begin
                            cur              <= StScan;
                            scan_idx         <= '0;
                            results_valid    <= 1'b0;
                            scan_from_closed <= 1'b1;
                            close_pending    <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_multi_ballot_controller.sv
// Randomized and directed bench for multi_ballot_controller against a behavioural ballot model.
module tb_multi_ballot_controller;
    localparam int ID_W     = 8;
    localparam int NUM_CAND = 8;
    localparam int CAND_W   = 4;
    localparam int CNT_W    = 4;
    localparam int TIMEOUT  = 64;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset, enable, poll_close, auth_req, submit, cancel, result_req;
    logic [ID_W-1:0]   voter_id;
    logic [CAND_W-1:0] cand_sel;
    logic              ready, vote_accepted, vote_rejected, tie, results_valid;
    logic [1:0]        state;
    logic [2:0]        err_code;
    logic [CNT_W-1:0]  total_votes, winner_votes;
    logic [CAND_W-1:0] winner_id;

    multi_ballot_controller #(
        .ID_W(ID_W), .NUM_CAND(NUM_CAND), .CAND_W(CAND_W), .CNT_W(CNT_W),
        .ID_MIN(1), .ID_MAX(200), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .poll_close(poll_close),
        .auth_req(auth_req), .voter_id(voter_id), .submit(submit), .cancel(cancel),
        .cand_sel(cand_sel), .result_req(result_req), .ready(ready), .state(state),
        .vote_accepted(vote_accepted), .vote_rejected(vote_rejected), .err_code(err_code),
        .total_votes(total_votes), .winner_id(winner_id), .winner_votes(winner_votes),
        .tie(tie), .results_valid(results_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: 0 idle, 1 session, 2 scan, 3 closed.
    int m_state, m_err, m_total, m_win, m_wv, m_voter, m_idle, m_scan_left;
    bit m_ready, m_acc, m_rej, m_tie, m_rv, m_from_closed, m_pend;
    int m_counts [NUM_CAND];
    bit m_voted [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = 0; m_err = 0; m_total = 0; m_win = 0; m_wv = 0; m_voter = 0;
        m_idle = 0; m_scan_left = 0; m_ready = 0; m_acc = 0; m_rej = 0; m_tie = 0;
        m_rv = 0; m_from_closed = 0; m_pend = 0;
        foreach (m_counts[i]) m_counts[i] = 0;
        foreach (m_voted[i]) m_voted[i] = 0;
    endfunction

    function automatic void start_scan(bit from_closed);
        m_state = 2; m_scan_left = NUM_CAND + 1; m_rv = 0;
        m_from_closed = from_closed; m_pend = 0;
    endfunction

    function automatic void finish_scan();
        int best = 0;
        int id = 0;
        foreach (m_counts[i]) if (m_counts[i] > best) begin best = m_counts[i]; id = i; end
        m_win = id; m_wv = best; m_tie = 0;
        foreach (m_counts[i]) if (i != id && m_counts[i] == best) m_tie = 1;
        m_rv = 1;
        m_state = (m_from_closed || m_pend) ? 3 : 0;
    endfunction

    function automatic void model_step();
        int id = int'(voter_id);
        int c = int'(cand_sel);
        m_acc = 0; m_rej = 0; m_ready = enable;
        if (!enable) begin
            if (m_state == 1) m_state = 0;
            else if (m_state == 2) begin m_state = m_from_closed ? 3 : 0; m_rv = 0; end
            return;
        end
        case (m_state)
            0: begin
                if (poll_close) m_state = 3;
                else if (auth_req) begin
                    if (id < 1 || id > 200) begin m_rej = 1; m_err = 1; end
                    else if (m_voted[id]) begin m_rej = 1; m_err = 2; end
                    else begin m_voter = id; m_err = 0; m_state = 1; m_idle = 0; end
                end else if (result_req) start_scan(0);
            end
            1: begin
                if (poll_close) m_state = 3;
                else if (cancel) m_state = 0;
                else if (submit) begin
                    if (c < NUM_CAND) begin
                        if (m_counts[c] < CNT_MAX) m_counts[c]++;
                        if (m_total < CNT_MAX) m_total++;
                        m_voted[m_voter] = 1; m_acc = 1; m_err = 0; m_rv = 0; m_state = 0;
                    end else begin
                        m_rej = 1; m_err = 3; m_idle = 0;
                    end
                end else begin
                    m_idle++;
                    if (m_idle >= TIMEOUT) begin m_rej = 1; m_err = 4; m_state = 0; end
                end
            end
            2: begin
                if (poll_close) m_pend = 1;
                m_scan_left--;
                if (m_scan_left == 0) finish_scan();
            end
            default: begin
                if (auth_req) begin m_rej = 1; m_err = 5; end
                else if (result_req) start_scan(1);
            end
        endcase
    endfunction

    task automatic compare_all(input string p);
        check({p, ".ready"}, ready, m_ready);
        check({p, ".state"}, state, m_state);
        check({p, ".acc"}, vote_accepted, m_acc);
        check({p, ".rej"}, vote_rejected, m_rej);
        check({p, ".err"}, err_code, m_err);
        check({p, ".total"}, total_votes, m_total);
        check({p, ".win_id"}, winner_id, m_win);
        check({p, ".win_votes"}, winner_votes, m_wv);
        check({p, ".tie"}, tie, m_tie);
        check({p, ".rvalid"}, results_valid, m_rv);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        #1;
        compare_all("cyc");
    endtask

    task automatic clear_req();
        auth_req = 0; submit = 0; cancel = 0; result_req = 0;
    endtask

    task automatic auth(input int id);
        clear_req(); auth_req = 1; voter_id = ID_W'(id); tick(); clear_req();
    endtask

    task automatic vote(input int c);
        clear_req(); submit = 1; cand_sel = CAND_W'(c); tick(); clear_req();
    endtask

    task automatic sync_reset();
        reset = 1; tick(); reset = 0; enable = 1; poll_close = 0; tick();
    endtask

    initial begin
        reset = 1; enable = 0; poll_close = 0; voter_id = '0; cand_sel = '0;
        clear_req();
        model_reset();
        #3;
        compare_all("rst");
        repeat (2) tick();
        @(negedge clk);
        reset = 0; enable = 1;
        tick();
        check("ready_up", ready, 1);

        // Accept, then reject the same voter
        auth(5); check("r25_state", state, 1);
        vote(2); check("r25_acc", vote_accepted, 1); check("r25_total", total_votes, 1);
        tick(); check("r25_pulse_len", vote_accepted, 0);
        auth(5); check("r25_rej", vote_rejected, 1); check("r25_err", err_code, 2);

        // Range boundaries
        auth(0);   check("r26_rej0", vote_rejected, 1); check("r26_err0", err_code, 1);
        check("r26_state0", state, 0);
        auth(201); check("r26_rej201", vote_rejected, 1); check("r26_err201", err_code, 1);
        auth(200); check("id200_ok", state, 1);
        clear_req(); cancel = 1; tick(); clear_req(); check("cancel_state", state, 0);

        // Invalid candidate keeps the session
        auth(7); vote(9); check("r27_err", err_code, 3); check("r27_state", state, 1);
        vote(1); check("r27_acc", vote_accepted, 1); check("r27_err_clr", err_code, 0);

        // Session timeout
        auth(8);
        repeat (TIMEOUT - 1) tick();
        check("r28_pre_state", state, 1);
        tick(); check("r28_rej", vote_rejected, 1); check("r28_err", err_code, 4);
        check("r28_state", state, 0);
        auth(8); check("r28_reauth", state, 1);
        clear_req(); cancel = 1; submit = 1; cand_sel = 0; tick(); clear_req();
        check("cancel_prio_total", total_votes, 2); check("cancel_prio_acc", vote_accepted, 0);

        // Winner scan with a tie
        for (int i = 0; i < 4; i++) begin auth(10 + i); vote(i < 2 ? 3 : 5); end
        clear_req(); result_req = 1; tick(); clear_req();
        for (int i = 0; i < NUM_CAND; i++) begin tick(); check("r29_wait", results_valid, 0); end
        tick(); check("r29_valid", results_valid, 1); check("r29_win", winner_id, 3);
        check("r29_votes", winner_votes, 2); check("r29_tie", tie, 1); check("r29_state", state, 0);

        // result_req ignored in session; enable drop aborts session and scan
        auth(14); clear_req(); result_req = 1; tick(); clear_req(); check("rr_in_sess", state, 1);
        enable = 0; tick(); check("en_sess", state, 0); enable = 1;
        clear_req(); result_req = 1; tick(); clear_req(); repeat (3) tick();
        enable = 0; tick(); check("en_scan", state, 0); check("en_scan_rv", results_valid, 0);
        enable = 1; tick();

        // Asynchronous reset mid-scan
        clear_req(); result_req = 1; tick(); clear_req(); tick();
        #2 reset = 1;
        #1 model_reset();
        compare_all("arst");
        tick();
        @(negedge clk);
        reset = 0; tick();

        // Randomized traffic with periodic quiet stretches and resets
        for (int n = 0; n < 4000; n++) begin
            if (n % 1500 == 1499) begin
                sync_reset();
            end else if (n % 600 >= 520) begin
                clear_req(); enable = 1; tick();
            end else begin
                enable     = ($urandom_range(0, 49) != 0);
                auth_req   = ($urandom_range(0, 3) == 0);
                voter_id   = ID_W'($urandom_range(0, 255));
                submit     = ($urandom_range(0, 3) == 0);
                cand_sel   = CAND_W'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 15)
                                                                 : $urandom_range(0, 8));
                cancel     = ($urandom_range(0, 15) == 0);
                result_req = ($urandom_range(0, 19) == 0);
                tick();
            end
        end
        clear_req(); enable = 1;
        sync_reset();

        // poll_close held during a scan closes the poll when the scan ends
        auth(30); vote(4);
        clear_req(); result_req = 1; tick(); clear_req();
        repeat (3) tick();
        poll_close = 1;
        repeat (NUM_CAND - 2) tick();
        check("close_scan_state", state, 3); check("close_scan_rv", results_valid, 1);
        check("close_scan_win", winner_id, 4);
        sync_reset();

        // poll_close mid-session, then CLOSED behaviour
        auth(20); poll_close = 1; tick(); check("r30_state", state, 3);
        check("r30_acc", vote_accepted, 0);
        auth(21); check("r30_rej", vote_rejected, 1); check("r30_err", err_code, 5);
        vote(0); check("closed_submit", total_votes, 0);
        clear_req(); result_req = 1; tick(); clear_req();
        repeat (NUM_CAND + 1) tick();
        check("closed_scan_state", state, 3); check("closed_scan_tie", tie, 1);
        check("closed_scan_rv", results_valid, 1);
        #2 reset = 1;
        #1 model_reset();
        compare_all("r30_rst");
        tick();
        @(negedge clk);
        reset = 0; poll_close = 0; enable = 1;
        tick();
        auth(5); check("r30_auth5", state, 1);
        vote(2); check("r30_acc5", vote_accepted, 1); check("r30_total", total_votes, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/multi_ballot_controller.md
MULTI_BALLOT_CONTROLLER -- requirements
Module: multi_ballot_controller

Interface
REQ-001 SHALL have parameter ID_W, default 8, voter ID width; the voted-flag registry holds 2^ID_W entries.
REQ-002 SHALL have parameter NUM_CAND, default 8, candidate count (2..16).
REQ-003 SHALL have parameter CAND_W, default 4, candidate index width (2^CAND_W >= NUM_CAND).
REQ-004 SHALL have parameter CNT_W, default 16, width of every vote counter.
REQ-005 SHALL have parameters ID_MIN, default 1, and ID_MAX, default 200, the inclusive valid voter-ID range.
REQ-006 SHALL have parameter TIMEOUT, default 64, the session idle limit in cycles.
REQ-007 SHALL have ports, in this order:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  system enable.
- poll_close  in  1  level; closes poll permanently until reset.
- auth_req  in  1  request to authenticate voter_id.
- voter_id  in  ID_W  voter identity.
- submit  in  1  cast vote for cand_sel.
- cancel  in  1  abandon session without voting.
- cand_sel  in  CAND_W  selected candidate.
- result_req  in  1  start winner scan.
- ready  out  1  registered copy of enable.
- state  out  2  0 IDLE, 1 SESSION, 2 SCAN, 3 CLOSED.
- vote_accepted  out  1  one-cycle pulse.
- vote_rejected  out  1  one-cycle pulse.
- err_code  out  3  held until the next auth_req or submit outcome.
- total_votes  out  CNT_W  accepted-vote total.
- winner_id  out  CAND_W  scan result.
- winner_votes  out  CNT_W  winner's count.
- tie  out  1  another candidate equals winner_votes.
- results_valid  out  1  scan results current.

Function
REQ-008 SHALL implement FSM IDLE, SESSION, SCAN, CLOSED; all inputs sampled on rising clk.
REQ-009 In IDLE with auth_req=1: voter_id outside [ID_MIN,ID_MAX] -> vote_rejected pulse, err_code=1; voter already voted -> vote_rejected pulse, err_code=2; otherwise latch voter_id, err_code=0, go SESSION.
REQ-010 In SESSION with submit=1 and cand_sel<NUM_CAND: next cycle vote_accepted pulse, increment that candidate's counter and total_votes, set the latched voter's voted flag, clear results_valid, go IDLE.
REQ-011 In SESSION with submit=1 and cand_sel>=NUM_CAND: vote_rejected pulse, err_code=3, remain SESSION, timeout restarts.
REQ-012 In SESSION, cancel=1 (priority over submit) SHALL go IDLE, no pulse, voter not marked.
REQ-013 In SESSION, TIMEOUT consecutive cycles without submit SHALL give vote_rejected pulse, err_code=4, go IDLE, voter not marked.
REQ-014 auth_req in SESSION SHALL be ignored.
REQ-015 Counters SHALL saturate at 2^CNT_W-1; a saturated vote is still accepted and marks the voter.
REQ-016 result_req in IDLE or CLOSED SHALL enter SCAN, visiting one candidate per cycle from index 0; results_valid SHALL rise exactly NUM_CAND+1 cycles after result_req is sampled; FSM then returns to its originating state.
REQ-017 Scan: highest count wins; equal counts keep the lower index; tie=1 if any other candidate equals winner_votes; all-zero -> winner_id=0, tie=1.
REQ-018 result_req in SESSION or SCAN SHALL be ignored.
REQ-019 poll_close=1 SHALL force CLOSED from IDLE or SESSION (session dropped, voter not marked); CLOSED persists until reset.
REQ-020 A request made during a scan started from IDLE SHALL not be queued; once a scan completes, the FSM enters CLOSED if poll_close=1.
REQ-021 In CLOSED, auth_req SHALL give vote_rejected pulse, err_code=5; submit SHALL be ignored.
REQ-022 enable=0 SHALL force IDLE from SESSION or SCAN (scan aborted, results_valid=0) without clearing counters or flags; all request inputs ignored.
REQ-023 In IDLE, simultaneous auth_req and result_req: auth_req wins.

Reset
REQ-024 reset SHALL clear all counters, total_votes, voted flags, err_code, winner_id, winner_votes, tie, results_valid, ready, vote_accepted, vote_rejected; state=IDLE; effective immediately, mid-session or mid-scan included.

Verification
REQ-025 Auth id 5, submit cand 2 -> vote_accepted 1 cycle, total_votes=1; re-auth id 5 -> vote_rejected, err_code=2.
REQ-026 Auth id 0 and id 201 -> vote_rejected, err_code=1 each, state stays 0.
REQ-027 Auth id 7, submit cand 9 -> err_code=3, state 1; submit cand 1 -> accepted.
REQ-028 Auth id 8, idle 64 cycles -> vote_rejected, err_code=4; re-auth id 8 succeeds.
REQ-029 Votes cand 3 x2 and cand 5 x2, result_req -> results_valid after 9 cycles, winner_id=3, winner_votes=2, tie=1.
REQ-030 poll_close mid-session, then auth -> err_code=5; reset -> all outputs 0, id 5 may vote again.
